// File: rtl/rf_write_arbiter_pkg.sv
// rtl/rf_write_arbiter_pkg.sv - shared widths, write-mode and state encodings for rf_write_arbiter
package rf_write_arbiter_pkg;

    localparam int WIDTH        = 32;
    localparam int REG_ADDR_LEN = 5;

    localparam logic [1:0] WMODE_WORD = 2'd0;
    localparam logic [1:0] WMODE_HALF = 2'd1;
    localparam logic [1:0] WMODE_BYTE = 2'd2;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rf_write_arbiter_starve_counter.sv
// rtl/rf_write_arbiter_starve_counter.sv - saturating wait counter for the secondary writer
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clr         clear to zero (wins over inc)
//   inc         count one wait cycle, saturating at LIMIT
//   at_limit    counter equals LIMIT
module starve_counter #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic at_limit
);

    localparam int CW = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LIMIT_V = CW'(LIMIT);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != LIMIT_V)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign at_limit = (cnt_q == LIMIT_V);

endmodule

// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - register-file write port arbiter with halt drain sequencing
//
// Writeback always wins the single write port; a secondary valid/ready writer
// (mul/div, late load) uses the port when writeback is idle. On wb_halt the
// block drains pending secondary writes, then raises a sticky halt_out.
//
// Optional build macro: RF_ARB_STARVE_GUARD_EN enables a starvation guard that
// raises stall_req after STARVE_LIMIT cycles of a blocked secondary request.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   wb_wr_en/addr/data/w_mode        writeback write request (primary)
//   wb_halt                          HALT retired pulse
//   sec_valid/ready/addr/data/w_mode secondary write handshake
//   stall_req                        asks pipeline for a writeback bubble
//   rf_wr_en/addr/data/w_mode        registered register-file write port
//   halt_out                         processor halted, sticky until reset
module rf_write_arbiter #(
    parameter int WIDTH        = 32,
    parameter int REG_ADDR_LEN = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wb_wr_en,
    input  logic [REG_ADDR_LEN-1:0] wb_addr,
    input  logic [WIDTH-1:0]        wb_data,
    input  logic [1:0]              wb_w_mode,
    input  logic                    wb_halt,
    input  logic                    sec_valid,
    output logic                    sec_ready,
    input  logic [REG_ADDR_LEN-1:0] sec_addr,
    input  logic [WIDTH-1:0]        sec_data,
    input  logic [1:0]              sec_w_mode,
    output logic                    stall_req,
    output logic                    rf_wr_en,
    output logic [REG_ADDR_LEN-1:0] rf_addr,
    output logic [WIDTH-1:0]        rf_data,
    output logic [1:0]              rf_w_mode,
    output logic                    halt_out
);

    import rf_write_arbiter_pkg::*;

    arb_state_t state_q, state_d;
    logic       wb_grant;
    logic       sec_grant;

    // Writeback only counts as a request in RUN; in DRAIN/HALTED it is ignored.
    assign wb_grant  = (state_q == ST_RUN) && wb_wr_en;
    assign sec_ready = (state_q != ST_HALTED) && !(wb_wr_en && (state_q == ST_RUN));
    assign sec_grant = !wb_grant && sec_valid && sec_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:    if (wb_halt)    state_d = ST_DRAIN;
            ST_DRAIN:  if (!sec_valid) state_d = ST_HALTED;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Address/data/mode hold their last granted value; only rf_wr_en pulses.
    // Writes to register 0 still consume the grant but never enable the port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_wr_en  <= 1'b0;
            rf_addr   <= '0;
            rf_data   <= '0;
            rf_w_mode <= WMODE_WORD;
        end else if (wb_grant) begin
            rf_wr_en  <= (wb_addr != '0);
            rf_addr   <= wb_addr;
            rf_data   <= wb_data;
            rf_w_mode <= wb_w_mode;
        end else if (sec_grant) begin
            rf_wr_en  <= (sec_addr != '0);
            rf_addr   <= sec_addr;
            rf_data   <= sec_data;
            rf_w_mode <= sec_w_mode;
        end else begin
            rf_wr_en  <= 1'b0;
        end
    end

    assign halt_out = (state_q == ST_HALTED);

`ifdef RF_ARB_STARVE_GUARD_EN
    // Counts cycles the secondary is blocked by writeback in RUN. If the
    // pipeline ignores stall_req, writeback still wins and the count stays
    // saturated because neither clear condition holds.
    starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (sec_grant || !sec_valid),
        .inc      (sec_valid && !sec_ready && (state_q == ST_RUN)),
        .at_limit (stall_req)
    );
`else
    assign stall_req = 1'b0;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - directed self-checking bench for rf_write_arbiter
module tb_rf_write_arbiter;

    logic        clk;
    logic        rst_n;
    logic        wb_wr_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [1:0]  wb_w_mode;
    logic        wb_halt;
    logic        sec_valid;
    logic        sec_ready;
    logic [4:0]  sec_addr;
    logic [31:0] sec_data;
    logic [1:0]  sec_w_mode;
    logic        stall_req;
    logic        rf_wr_en;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic [1:0]  rf_w_mode;
    logic        halt_out;

    int n_checks = 0;
    int n_errors = 0;

    rf_write_arbiter #(
        .WIDTH        (32),
        .REG_ADDR_LEN (5),
        .STARVE_LIMIT (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wb_wr_en   (wb_wr_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .wb_w_mode  (wb_w_mode),
        .wb_halt    (wb_halt),
        .sec_valid  (sec_valid),
        .sec_ready  (sec_ready),
        .sec_addr   (sec_addr),
        .sec_data   (sec_data),
        .sec_w_mode (sec_w_mode),
        .stall_req  (stall_req),
        .rf_wr_en   (rf_wr_en),
        .rf_addr    (rf_addr),
        .rf_data    (rf_data),
        .rf_w_mode  (rf_w_mode),
        .halt_out   (halt_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_rf(input string tag, input logic en, input logic [4:0] addr,
                            input logic [31:0] data, input logic [1:0] mode);
        check({tag, "_en"}, 32'(rf_wr_en), 32'(en));
        check({tag, "_addr"}, 32'(rf_addr), 32'(addr));
        check({tag, "_data"}, rf_data, data);
        check({tag, "_mode"}, 32'(rf_w_mode), 32'(mode));
    endtask

    initial begin
        rst_n = 1'b0;
        wb_wr_en = 1'b0; wb_addr = '0; wb_data = '0; wb_w_mode = 2'd0; wb_halt = 1'b0;
        sec_valid = 1'b0; sec_addr = '0; sec_data = '0; sec_w_mode = 2'd0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // reset / idle state
        check_rf("reset", 1'b0, 5'd0, 32'h0, 2'd0);
        check("reset_halt", 32'(halt_out), 32'd0);
        check("reset_stall", 32'(stall_req), 32'd0);
        check("idle_ready", 32'(sec_ready), 32'd1);

        // basic writeback write, one register stage
        wb_wr_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF; wb_w_mode = 2'd0;
        tick();
        check_rf("wb5", 1'b1, 5'd5, 32'hDEADBEEF, 2'd0);
        wb_wr_en = 1'b0;
        tick();
        check("wb5_pulse", 32'(rf_wr_en), 32'd0);

        // collision: writeback wins, secondary follows next cycle
        wb_wr_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h33; wb_w_mode = 2'd2;
        sec_valid = 1'b1; sec_addr = 5'd7; sec_data = 32'h12; sec_w_mode = 2'd1;
        #1;
        check("coll_ready0", 32'(sec_ready), 32'd0);
        tick();
        check_rf("coll_wb", 1'b1, 5'd3, 32'h33, 2'd2);
        wb_wr_en = 1'b0;
        #1;
        check("coll_ready1", 32'(sec_ready), 32'd1);
        tick();
        check_rf("coll_sec", 1'b1, 5'd7, 32'h12, 2'd1);

        // zero register: handshake completes, no write
        sec_addr = 5'd0; sec_data = 32'h55; sec_w_mode = 2'd0;
        #1;
        check("zero_ready", 32'(sec_ready), 32'd1);
        tick();
        check("zero_sec_en", 32'(rf_wr_en), 32'd0);
        sec_valid = 1'b0;
        wb_wr_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h66;
        tick();
        check("zero_wb_en", 32'(rf_wr_en), 32'd0);
        wb_wr_en = 1'b0;

        // halt drain: wb write in halt cycle granted, then 3 secondary writes
        wb_wr_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h99; wb_w_mode = 2'd0; wb_halt = 1'b1;
        sec_valid = 1'b1; sec_addr = 5'd10; sec_data = 32'hA0; sec_w_mode = 2'd0;
        tick();
        check_rf("halt_wb", 1'b1, 5'd9, 32'h99, 2'd0);
        wb_halt = 1'b0; wb_addr = 5'd11; wb_data = 32'hBB;
        #1;
        check("drain_ready", 32'(sec_ready), 32'd1);
        tick();
        check_rf("drain1", 1'b1, 5'd10, 32'hA0, 2'd0);
        sec_addr = 5'd12; sec_data = 32'hC0;
        tick();
        check_rf("drain2", 1'b1, 5'd12, 32'hC0, 2'd0);
        sec_addr = 5'd13; sec_data = 32'hD0; sec_w_mode = 2'd2;
        tick();
        check_rf("drain3", 1'b1, 5'd13, 32'hD0, 2'd2);
        check("drain_halt0", 32'(halt_out), 32'd0);
        sec_valid = 1'b0;
        tick();
        check("halted_en", 32'(rf_wr_en), 32'd0);
        check("halted_out", 32'(halt_out), 32'd1);
        sec_valid = 1'b1; sec_addr = 5'd20; wb_addr = 5'd14; wb_halt = 1'b1;
        #1;
        check("halted_ready", 32'(sec_ready), 32'd0);
        tick();
        check("halted_en2", 32'(rf_wr_en), 32'd0);
        check("halted_sticky", 32'(halt_out), 32'd1);
        wb_halt = 1'b0; wb_wr_en = 1'b0; sec_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // async reset in the middle of DRAIN
        wb_wr_en = 1'b1; wb_addr = 5'd15; wb_data = 32'hF; wb_halt = 1'b1;
        tick();
        check("ar_wb", 32'(rf_wr_en), 32'd1);
        wb_wr_en = 1'b0; wb_halt = 1'b0;
        sec_valid = 1'b1; sec_addr = 5'd16; sec_data = 32'h16;
        tick();
        check_rf("ar_drain", 1'b1, 5'd16, 32'h16, 2'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check_rf("ar_clear", 1'b0, 5'd0, 32'h0, 2'd0);
        check("ar_halt", 32'(halt_out), 32'd0);
        check("ar_ready", 32'(sec_ready), 32'd1);
        sec_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("ar_post_halt", 32'(halt_out), 32'd0);
        wb_wr_en = 1'b1; wb_addr = 5'd2; wb_data = 32'h22; wb_w_mode = 2'd1;
        tick();
        check_rf("ar_post_wb", 1'b1, 5'd2, 32'h22, 2'd1);

        // starvation: writeback held while secondary waits
        wb_addr = 5'd4; wb_data = 32'h44; wb_w_mode = 2'd0;
        sec_valid = 1'b1; sec_addr = 5'd8; sec_data = 32'h88; sec_w_mode = 2'd0;
        tick();
        tick();
        tick();
        check("starve_3", 32'(stall_req), 32'd0);
        tick();
`ifdef RF_ARB_STARVE_GUARD_EN
        check("starve_4", 32'(stall_req), 32'd1);
`else
        check("starve_4", 32'(stall_req), 32'd0);
`endif
        check_rf("starve_wb", 1'b1, 5'd4, 32'h44, 2'd0);
        tick();
`ifdef RF_ARB_STARVE_GUARD_EN
        check("starve_sat", 32'(stall_req), 32'd1);
`else
        check("starve_sat", 32'(stall_req), 32'd0);
`endif
        wb_wr_en = 1'b0;
        #1;
        check("starve_ready", 32'(sec_ready), 32'd1);
        tick();
        check_rf("starve_sec", 1'b1, 5'd8, 32'h88, 2'd0);
        check("starve_clear", 32'(stall_req), 32'd0);
        sec_valid = 1'b0;
        tick();
        check("final_idle_en", 32'(rf_wr_en), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
